// File: rtl/moore_seq_detector_n_if.sv
// moore_seq_detector_n_if: control, configuration and status bundle for the sequence detector.
//   en          sample enable          in           serial data bit
//   cfg_we      configuration strobe   cfg_len      pattern length (0 -> 1, >MAX_LEN -> MAX_LEN)
//   cfg_pat     right-aligned pattern  cfg_overlap  1 = overlapping matches allowed
//   cnt_clr     synchronous match_cnt clear
//   match       high while in HIT      match_cnt    saturating HIT-entry count
//   state       IDLE=0 FILL=1 HUNT=2 HIT=3
interface moore_seq_detector_n_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    logic               en;
    logic               in;
    logic               cfg_we;
    logic [LEN_W-1:0]   cfg_len;
    logic [MAX_LEN-1:0] cfg_pat;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic [1:0]         state;
    modport master (
        output en, in, cfg_we, cfg_len, cfg_pat, cfg_overlap, cnt_clr,
        input  match, match_cnt, state
    );
    modport slave (
        input  en, in, cfg_we, cfg_len, cfg_pat, cfg_overlap, cnt_clr,
        output match, match_cnt, state
    );
endinterface

// File: rtl/moore_seq_detector_n.sv
// moore_seq_detector_n: programmable Moore detector for a serial bit pattern of up to MAX_LEN bits.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (len=2, pat=11, overlap=1, counters cleared)
//   bus  moore_seq_detector_n_if.slave: sample/config inputs, match/match_cnt/state outputs
module moore_seq_detector_n #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic                   clk,
    input logic                   rst,
    moore_seq_detector_n_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, HUNT = 2'd2, HIT = 2'd3} state_t;
    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, cfg_len_c;
    logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, mask, cand;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W:0]     fill_inc;
    logic               full, eq, hit;
    // Only the low len bits of the candidate and the pattern take part in the compare.
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
        assign mask[i] = len_q > LEN_W'(i);
    end
    assign cfg_len_c = bus.cfg_len == '0 ? LEN_W'(1) :
                       bus.cfg_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : bus.cfg_len;
    assign cand      = {hist_q[MAX_LEN-2:0], bus.in};
    assign fill_inc  = {1'b0, fill_q} + (LEN_W + 1)'(1);
    assign full      = fill_inc >= {1'b0, len_q};
    assign eq        = ((cand ^ pat_q) & mask) == '0;
    // A configuration write discards the sample on the same edge, so it can never produce a hit.
    assign hit       = bus.en && !bus.cfg_we && full && eq;
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pat_d     = pat_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        if (bus.cfg_we) begin
            len_d     = cfg_len_c;
            pat_d     = bus.cfg_pat;
            overlap_d = bus.cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = IDLE;
        end else if (bus.en) begin
            hist_d  = cand;
            // Non-overlapping mode forgets the matched bits so the next hit needs len fresh ones.
            fill_d  = hit && !overlap_q ? '0 : full ? len_q : fill_inc[LEN_W-1:0];
            state_d = hit ? HIT : full ? HUNT : FILL;
        end
    end
    assign cnt_d = bus.cnt_clr ? '0 : hit && cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= LEN_W'(2);
            pat_q     <= MAX_LEN'(3);
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            pat_q     <= pat_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
        end
    end
    assign bus.match     = state_q == HIT;
    assign bus.match_cnt = cnt_q;
    assign bus.state     = state_q;
endmodule
